// File: rtl/pwm_capture_tx.sv
// PWM frequency/duty capture with periodic UDP status reporting on AXI-Stream.
// Each channel is measured continuously; a report tick scans all channels through one shared divider.
module pwm_capture_tx #(
    parameter int unsigned PWM_NUM       = 5,
    parameter logic [7:0]  ID_PWM_STATUS = 8'd1,
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned REPORT_PERIOD = 10000000,
    parameter int unsigned TIMEOUT       = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PWM_NUM-1:0] pwm_in,
    output logic [31:0]        tx_axis_udp_tdata,
    output logic               tx_axis_udp_tvalid,
    output logic               tx_axis_udp_tlast,
    output logic [7:0]         tx_axis_udp_tuser,
    input  logic               tx_axis_udp_tready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_DIV_F,
        S_DIV_D,
        S_SEND
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] beat_word(input logic [2:0]  idx,
                                              input logic [7:0]  ch,
                                              input logic [31:0] freq,
                                              input logic [6:0]  duty,
                                              input logic        act);
        case (idx)
            3'd0:    return {24'd0, ch};
            3'd1:    return freq;
            3'd2:    return {25'd0, duty};
            3'd3:    return 32'd0;
            3'd4:    return {31'd0, act};
            default: return 32'd0;
        endcase
    endfunction

    logic [PWM_NUM-1:0] sync1_q, sync2_q, sync3_q;
    logic [PWM_NUM-1:0] valid_q, seen_q, lvl_q;
    logic [31:0]        per_cnt_q    [PWM_NUM];
    logic [31:0]        hi_cnt_q     [PWM_NUM];
    logic [31:0]        period_lat_q [PWM_NUM];
    logic [31:0]        high_lat_q   [PWM_NUM];

    state_t      state_q;
    logic [8:0]  ch_q;
    logic [5:0]  cyc_q;
    logic [2:0]  beat_q;
    logic [31:0] timer_q;
    logic [31:0] snap_period_q, snap_high_q;
    logic        snap_valid_q, snap_lvl_q;
    logic [31:0] rem_q;
    logic [39:0] quo_q;
    logic [31:0] freq_q;
    logic [6:0]  duty_q;
    logic        active_q;
    logic [31:0] tdata_q;
    logic        tvalid_q, tlast_q;
    logic [7:0]  tuser_q;

    logic [31:0] snap_period_d, snap_high_d;
    logic        snap_valid_d, snap_lvl_d;
    logic [32:0] div_trial_d;
    logic [31:0] rem_d;
    logic [39:0] quo_d;
    logic        tick_d;

    assign tx_axis_udp_tdata  = tdata_q;
    assign tx_axis_udp_tvalid = tvalid_q;
    assign tx_axis_udp_tlast  = tlast_q;
    assign tx_axis_udp_tuser  = tuser_q;

    // Synchronise inputs and run per-channel period/high counters, latches and validity tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            lvl_q   <= '0;
            for (int i = 0; i < PWM_NUM; i++) begin
                per_cnt_q[i]    <= 32'd0;
                hi_cnt_q[i]     <= 32'd0;
                period_lat_q[i] <= 32'd0;
                high_lat_q[i]   <= 32'd0;
            end
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            for (int i = 0; i < PWM_NUM; i++) begin
                if (sync2_q[i] && !sync3_q[i]) begin
                    // Restart at 1: the edge cycle itself belongs to the new interval (and is high).
                    period_lat_q[i] <= per_cnt_q[i];
                    high_lat_q[i]   <= hi_cnt_q[i];
                    per_cnt_q[i]    <= 32'd1;
                    hi_cnt_q[i]     <= 32'd1;
                    valid_q[i]      <= valid_q[i] | seen_q[i];
                    seen_q[i]       <= 1'b1;
                end else begin
                    per_cnt_q[i] <= sat_inc(per_cnt_q[i]);
                    hi_cnt_q[i]  <= sync2_q[i] ? sat_inc(hi_cnt_q[i]) : hi_cnt_q[i];
                    if (per_cnt_q[i] == TIMEOUT) begin
                        valid_q[i] <= 1'b0;
                        seen_q[i]  <= 1'b0;
                        lvl_q[i]   <= sync2_q[i];
                    end else begin
                        valid_q[i] <= valid_q[i];
                    end
                end
            end
        end
    end

    // Select the current channel's measurement for the snapshot.
    always_comb begin
        snap_period_d = 32'd0;
        snap_high_d   = 32'd0;
        snap_valid_d  = 1'b0;
        snap_lvl_d    = 1'b0;
        for (int i = 0; i < PWM_NUM; i++) begin
            snap_period_d = (ch_q == 9'(i)) ? period_lat_q[i] : snap_period_d;
            snap_high_d   = (ch_q == 9'(i)) ? high_lat_q[i]   : snap_high_d;
            snap_valid_d  = (ch_q == 9'(i)) ? valid_q[i]      : snap_valid_d;
            snap_lvl_d    = (ch_q == 9'(i)) ? lvl_q[i]        : snap_lvl_d;
        end
    end

    // One restoring-division step: quo_q shifts dividend bits out and quotient bits in.
    always_comb begin
        div_trial_d = {rem_q, quo_q[39]};
        if (div_trial_d >= {1'b0, snap_period_q}) begin
            rem_d = 32'(div_trial_d - {1'b0, snap_period_q});
            quo_d = {quo_q[38:0], 1'b1};
        end else begin
            rem_d = div_trial_d[31:0];
            quo_d = {quo_q[38:0], 1'b0};
        end
    end

    assign tick_d = (timer_q == 32'(REPORT_PERIOD - 1));

    // Free-running report timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= tick_d ? 32'd0 : timer_q + 32'd1;
        end
    end

    // Scan FSM: snapshot, two divisions, then one five-beat frame per channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ch_q          <= 9'd0;
            cyc_q         <= 6'd0;
            beat_q        <= 3'd0;
            snap_period_q <= 32'd0;
            snap_high_q   <= 32'd0;
            snap_valid_q  <= 1'b0;
            snap_lvl_q    <= 1'b0;
            rem_q         <= 32'd0;
            quo_q         <= 40'd0;
            freq_q        <= 32'd0;
            duty_q        <= 7'd0;
            active_q      <= 1'b0;
            tdata_q       <= 32'd0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_d) begin
                        ch_q    <= 9'd0;
                        state_q <= S_SNAP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SNAP: begin
                    snap_period_q <= snap_period_d;
                    snap_high_q   <= snap_high_d;
                    snap_valid_q  <= snap_valid_d;
                    snap_lvl_q    <= snap_lvl_d;
                    rem_q         <= 32'd0;
                    quo_q         <= 40'(CLK_FREQ);
                    cyc_q         <= 6'd0;
                    state_q       <= S_DIV_F;
                end
                S_DIV_F: begin
                    cyc_q <= cyc_q + 6'd1;
                    if (cyc_q == 6'd39) begin
                        freq_q  <= snap_valid_q ? quo_d[31:0] : 32'd0;
                        rem_q   <= 32'd0;
                        quo_q   <= 40'(snap_high_q) * 40'd100;
                        cyc_q   <= 6'd0;
                        state_q <= S_DIV_D;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                    end
                end
                S_DIV_D: begin
                    cyc_q <= cyc_q + 6'd1;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cyc_q == 6'd39) begin
                        if (snap_valid_q) begin
                            duty_q <= (quo_d > 40'd100) ? 7'd100 : quo_d[6:0];
                        end else begin
                            duty_q <= snap_lvl_q ? 7'd100 : 7'd0;
                        end
                        active_q <= snap_valid_q;
                        beat_q   <= 3'd0;
                        tdata_q  <= {24'd0, ch_q[7:0]};
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                        tuser_q  <= ID_PWM_STATUS;
                        state_q  <= S_SEND;
                    end else begin
                        state_q <= S_DIV_D;
                    end
                end
                S_SEND: begin
                    if (tx_axis_udp_tready) begin
                        if (beat_q == 3'd4) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tdata_q  <= 32'd0;
                            tuser_q  <= 8'd0;
                            ch_q     <= ch_q + 9'd1;
                            state_q  <= ((ch_q + 9'd1) < 9'(PWM_NUM)) ? S_SNAP : S_IDLE;
                        end else begin
                            beat_q  <= beat_q + 3'd1;
                            tdata_q <= beat_word(beat_q + 3'd1, ch_q[7:0], freq_q, duty_q, active_q);
                            tlast_q <= (beat_q == 3'd3);
                        end
                    end else begin
                        state_q <= S_SEND;
                    end
                end
                default: begin
                    tvalid_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture_tx.md
# pwm_capture_tx

Measures the frequency and duty cycle of `PWM_NUM` external PWM inputs and reports them to the host as UDP frames on a transmit AXI-Stream interface. It is the return path of the PWM subsystem: the frame layout matches the PWM parameter frame that `pwm_top` accepts on `rx_axis_udp_*`, so the host uses one parser for both directions. It sits between the board PWM input pins and the UDP stack transmit user port.

## Interface
- `PWM_NUM`, 5: number of measured input channels (1..256).
- `ID_PWM_STATUS`, 1: frame ID driven on `tx_axis_udp_tuser`.
- `CLK_FREQ`, 100000000: module clock frequency in Hz. It is the numerator of the frequency division.
- `REPORT_PERIOD`, 10000000: clk cycles between report ticks.
- `TIMEOUT`, 100000000: clk cycles without a rising edge before a channel is declared inactive.

Ports:
- `clk` in 1: module clock.
- `rst` in 1: reset. Synchronous, active-high.
- `pwm_in` in PWM_NUM: asynchronous PWM inputs.
- `tx_axis_udp_tdata` out 32: frame beat data.
- `tx_axis_udp_tvalid` out 1: beat valid.
- `tx_axis_udp_tlast` out 1: last beat of the frame.
- `tx_axis_udp_tuser` out 8: frame ID. Equals `ID_PWM_STATUS` on every beat.
- `tx_axis_udp_tready` in 1: downstream ready.

## Operation
- **Input synchronisation:** each `pwm_in` bit passes through a 2-flop synchroniser. A rising edge is detected on the synchronised signal.
- **Per-channel counters:** each channel has two 32-bit saturating counters.
  - `per_cnt` counts cycles since the last rising edge.
  - `hi_cnt` counts cycles with the synchronised input high.
- **On a rising edge:**
  - `period_lat` latches the cycle count between consecutive rising edges.
  - `high_lat` latches the high-cycle count within that interval.
  - Both counters restart.
  - `valid` is set on the second edge after reset or timeout.
- **Timeout:** when `per_cnt` reaches `TIMEOUT`, `valid` clears and the synchronised level is latched into `lvl`.
- **Report timer:** a free-running counter issues a tick every `REPORT_PERIOD` cycles. A tick that arrives while a scan is in progress is dropped, not queued.
- **Scan FSM states:** IDLE → SNAP → DIV_F → DIV_D → SEND → (next channel SNAP | IDLE).
  - **IDLE:** wait for a tick; set channel index = 0.
  - **SNAP** (1 cycle): atomically copy `period_lat`, `high_lat`, `valid` and `lvl` of the current channel. Measurement continues unaffected.
  - **DIV_F** (40 cycles): shared restoring divider, 40-bit dividend / 32-bit divisor, one quotient bit per cycle. Computes freq = floor(`CLK_FREQ` / period).
  - **DIV_D** (40 cycles): same divider computes duty = floor(high × 100 / period). The product is 40 bits wide. The result is clamped to 100.
  - **SEND:** emits 5 beats:
    1. `{24'b0, ch}`
    2. freq
    3. `{25'b0, duty}`
    4. `32'b0`
    5. `{31'b0, active}`, with `tlast` = 1
  - After beat 5 is accepted, the FSM increments the channel index. It goes to SNAP if the index is below `PWM_NUM`, otherwise to IDLE.
- **Invalid channel:** if the snapshot `valid` = 0, the divider results are overridden.
  - freq = 0.
  - duty = 100 if `lvl` else 0.
  - active = 0.
  - Divide latency is unchanged.
- **Valid channel:** active = 1.
- **Divide-by-zero:** not reachable, because a valid period is ≥ 2.

## Timing
- **Reset values:** all outputs are 0. FSM = IDLE. Report timer = 0. All `valid` = 0. Counters and latches = 0.
- **Reset mid-frame:** on the clock edge where `rst` is sampled high, `tvalid` drops and the partial frame is abandoned. No frame is emitted until the first tick after reset release.
- **Latency:** if SNAP is at cycle t, the first beat presents `tvalid` = 1 at cycle t+81.
- **Minimum scan length:** `PWM_NUM` × 86 cycles with `tready` held high.
- **AXI-Stream handshake:**
  - A beat transfers when `tvalid` && `tready`.
  - `tdata`, `tlast` and `tuser` hold stable while `tvalid` && !`tready`.
  - `tvalid` stays high for all 5 beats of a frame, with no bubbles.
  - `tvalid` is low outside SEND.
  - Frames are never interleaved.
- **Measurement resolution:** measured edges are delayed 2 cycles by the synchroniser. Period and high counts are exact in clk cycles at a constant input.

## Test plan
Bench parameters: `CLK_FREQ` = 100000000, `REPORT_PERIOD` = 20000, `TIMEOUT` = 50000, `PWM_NUM` = 5, `tready` = 1 unless stated.

- **100 kHz, 50%:** `pwm_in[0]` with period 1000 cycles, high 500 → ch0 frame beats 0, 100000, 50, 0, 1; `tlast` on beat 5 only; `tuser` = 1.
- **Non-integer period:** `pwm_in[1]` with period 1818 cycles, high 364 → freq 55005, duty 20, active 1.
- **Stuck inputs:** `pwm_in[2]` held high and `pwm_in[3]` held low for more than 50000 cycles → ch2 frame reports 0, 100, active 0; ch3 frame reports 0, 0, active 0.
- **Backpressure:** `tready` toggled pseudo-randomly → beat values are unchanged while stalled; channel order 0..4 per tick; 25 beats per tick; `tvalid` never drops mid-frame.
- **Reset mid-frame:** assert `rst` for 1 cycle during beat 3 → `tvalid` = 0 after that edge. The next frame appears only after the following tick and reports active 0 until two new edges are seen.
- **Dropped ticks:** with `REPORT_PERIOD` = 300 (shorter than one 430-cycle scan) → overlapping ticks are dropped, every frame is complete, and channel order is preserved.
